// File: rtl/elastic_pkg.sv
// Shared types for the elastic_skid two-entry ready/valid skid buffer.
package elastic_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/inelastic.sv
// Enable-only pipeline register; optionally cleared by reset when datapath_reset_p != 0.
module inelastic #(
    parameter int width_p          = 8,
    parameter int datapath_reset_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    // Data register: optional reset clear, otherwise load only when enabled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (datapath_reset_p != 0) begin
                data_q <= {width_p{1'b0}};
            end
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/elastic_skid.sv
// Two-entry ready/valid skid buffer with registered valid_o and ready_o.
// Define ELASTIC_SKID_ASSERT_EN to compile in simulation-only protocol assertions.
module elastic_skid
    import elastic_pkg::*;
#(
    parameter int width_p          = 8,
    parameter int datapath_reset_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] data_o
);

    state_e             state_q;
    state_e             state_d;
    logic               valid_q;
    logic               ready_q;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               main_en_s;
    logic               skid_en_s;
    logic               main_sel_skid_s;
    logic [width_p-1:0] main_in_s;
    logic [width_p-1:0] skid_data_s;

    assign in_fire_s  = valid_i & ready_q;
    assign out_fire_s = valid_q & ready_i;

    // Next-state and register load strobes; reset suppresses every load.
    always_comb begin
        state_d         = state_q;
        main_en_s       = 1'b0;
        skid_en_s       = 1'b0;
        main_sel_skid_s = 1'b0;
        if (reset_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        main_en_s = 1'b1;
                        state_d   = HALF;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                HALF: begin
                    if (in_fire_s && out_fire_s) begin
                        main_en_s = 1'b1;
                        state_d   = HALF;
                    end else if (in_fire_s) begin
                        skid_en_s = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = HALF;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        main_en_s       = 1'b1;
                        main_sel_skid_s = 1'b1;
                        state_d         = HALF;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign main_in_s = main_sel_skid_s ? skid_data_s : data_i;

    // State plus handshake flops, precomputed from the next state so outputs are pure flops.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != EMPTY);
            ready_q <= (state_d != FULL);
        end
    end

    inelastic #(
        .width_p         (width_p),
        .datapath_reset_p(datapath_reset_p)
    ) u_main (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (main_en_s),
        .data_i (main_in_s),
        .data_o (data_o)
    );

    inelastic #(
        .width_p         (width_p),
        .datapath_reset_p(datapath_reset_p)
    ) u_skid (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (skid_en_s),
        .data_i (data_i),
        .data_o (skid_data_s)
    );

    assign valid_o = valid_q;
    assign ready_o = ready_q;

`ifdef ELASTIC_SKID_ASSERT_EN
    a_stall_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (valid_o && !ready_i) |=> $stable(data_o))
        else $error("elastic_skid: data_o changed during stall");
    a_state_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q inside {EMPTY, HALF, FULL}))
        else $error("elastic_skid: illegal state encoding");
    a_ready_state: assert property (@(posedge clk_i) disable iff (reset_i)
        (ready_o == (state_q != FULL)))
        else $error("elastic_skid: ready_o inconsistent with state");
`endif

endmodule

// File: tb/tb_elastic_skid.sv
// Scoreboard bench for elastic_skid: directed scenarios plus 10k cycles of random traffic.
module tb_elastic_skid;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clk_i = ~clk_i;

    elastic_skid #(
        .width_p         (8),
        .datapath_reset_p(1)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: the model is just a FIFO of accepted items with capacity two.
    always @(negedge clk_i) begin
        if (reset_i) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            check("valid_o_vs_model", valid_o, sb.size() > 0);
            check("ready_o_vs_model", ready_o, sb.size() < 2);
            if (prev_stall) check("stall_hold", data_o, prev_data);
            if (valid_o && ready_i && sb.size() > 0) check("order", data_o, sb.pop_front());
            if (valid_i && ready_o) sb.push_back(data_i);
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
        end
    end

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'h00;
        step();
        step();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("reset_valid", valid_o, 1'b0);
        check("reset_ready", ready_o, 1'b1);
        check("reset_data", data_o, 8'h00);

        // Streaming at full rate
        ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            valid_i = 1'b1;
            data_i  = 8'(i);
        end
        step();
        valid_i = 1'b0;
        @(negedge clk_i);
        check("stream_last", data_o, 8'h10);
        repeat (3) step();

        // Fill to FULL with AA, BB and then release
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hAA;
        step();
        data_i  = 8'hBB;
        step();
        valid_i = 1'b0;
        @(negedge clk_i);
        check("full_ready", ready_o, 1'b0);
        check("full_data", data_o, 8'hAA);
        step();
        check("full_hold", data_o, 8'hAA);
        ready_i = 1'b1;
        step();
        @(negedge clk_i);
        check("drain_second", data_o, 8'hBB);
        check("drain_ready", ready_o, 1'b1);
        repeat (2) step();

        // Reset while FULL discards both items
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h11;
        step();
        data_i  = 8'h22;
        step();
        valid_i = 1'b0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("midreset_valid", valid_o, 1'b0);
        check("midreset_ready", ready_o, 1'b1);
        valid_i = 1'b1;
        data_i  = 8'h33;
        step();
        valid_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_first", data_o, 8'h33);
        check("post_reset_valid", valid_o, 1'b1);
        ready_i = 1'b1;
        repeat (2) step();

        // Simultaneous push and pop in HALF
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h55;
        step();
        ready_i = 1'b1;
        data_i  = 8'h66;
        step();
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk_i);
        check("half_swap_data", data_o, 8'h66);
        check("half_swap_ready", ready_o, 1'b1);
        check("half_swap_valid", valid_o, 1'b1);
        ready_i = 1'b1;
        repeat (2) step();

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            data_i  = 8'($urandom);
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) step();
        @(negedge clk_i);
        check("drained_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
